// File: rtl/seven_segment_pkg.sv
// ============================================================================
// Module      : seven_segment_pkg
// Description : Segment patterns, digit-select codes and FSM state type shared
//               by the seven-segment readback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_segment_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DSEL_TENS = 2'b10;
  localparam logic [1:0] DSEL_ONES = 2'b01;

  typedef enum logic [0:0] {
    S_TENS = 1'b0,
    S_ONES = 1'b1
  } state_t;

  // t*10 as shift-and-add; 9*10+9 fits in 7 bits
  function automatic logic [6:0] times_ten(input logic [3:0] t);
    logic [6:0] w_t;
    w_t = {3'b000, t};
    return (w_t << 3) + (w_t << 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_digit_decode.sv
// ============================================================================
// Module      : seven_segment_digit_decode
// Description : Combinational seven-segment pattern to BCD digit decoder with
//               optional blank-as-zero acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_digit_decode
  import seven_segment_pkg::*;
#(
  parameter bit BLANK_AS_ZERO = 1'b0
) (
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: legal = BLANK_AS_ZERO;
      default:   legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_to_decimal.sv
// ============================================================================
// Module      : seven_segment_to_decimal
// Description : Debounces a multiplexed two-digit seven-segment bus and
//               reassembles the 0-99 value. Macro SEVSEG_BLANK_TENS_EN lets a
//               blank tens digit decode as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_to_decimal
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] digit_sel,
  output logic [6:0] decimal,
  output logic       valid,
  output logic       error
);

`ifdef SEVSEG_BLANK_TENS_EN
  localparam bit c_blank_tens = 1'b1;
`else
  localparam bit c_blank_tens = 1'b0;
`endif

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  logic [8:0] w_sample;
  logic [8:0] r_sample;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_acc;
  state_t     r_state;
  logic [3:0] r_tens;

  logic       w_tens_legal;
  logic [3:0] w_tens_digit;
  logic       w_ones_legal;
  logic [3:0] w_ones_digit;
  logic [1:0] w_dsel;

  assign w_sample = {digit_sel, seg};
  assign w_dsel   = r_sample[8:7];

  // The run length is measured against the incoming sample so that an input
  // first present in cycle k is accepted in cycle k+STABLE_CYCLES.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_sample != r_sample)
      w_cnt_next = 4'd1;
    else if (r_cnt != c_stable)
      w_cnt_next = r_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= 9'd0;
      r_cnt    <= 4'd0;
      r_acc    <= 1'b0;
    end else begin
      r_sample <= w_sample;
      r_cnt    <= w_cnt_next;
      r_acc    <= (w_cnt_next == c_stable) && (r_cnt != c_stable);
    end
  end

  seven_segment_digit_decode #(
    .BLANK_AS_ZERO(c_blank_tens)
  ) u_dec_tens (
    .seg   (r_sample[6:0]),
    .legal (w_tens_legal),
    .digit (w_tens_digit)
  );

  seven_segment_digit_decode #(
    .BLANK_AS_ZERO(1'b0)
  ) u_dec_ones (
    .seg   (r_sample[6:0]),
    .legal (w_ones_legal),
    .digit (w_ones_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_TENS;
      r_tens  <= 4'd0;
      decimal <= 7'd0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (r_acc) begin
        if (w_dsel == DSEL_TENS) begin
          if (w_tens_legal) begin
            r_tens  <= w_tens_digit;
            r_state <= S_ONES;
          end else begin
            error   <= 1'b1;
            r_state <= S_TENS;
          end
        end else if (w_dsel == DSEL_ONES) begin
          if (!w_ones_legal) begin
            error   <= 1'b1;
            r_state <= S_TENS;
          end else if (r_state == S_ONES) begin
            decimal <= times_ten(r_tens) + {3'b000, w_ones_digit};
            valid   <= 1'b1;
            r_state <= S_TENS;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_to_decimal.sv
// ============================================================================
// Module      : tb_seven_segment_to_decimal
// Description : Randomised and directed bench against a run-length/frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_to_decimal;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic [6:0] decimal;
  logic       valid;
  logic       error;

  seven_segment_to_decimal #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .digit_sel (digit_sel),
    .decimal   (decimal),
    .valid     (valid),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference model state
  logic [8:0] m_prev;
  int         m_run;
  bit         m_have_tens;
  int         m_tens;
  bit         nx_v, nx_e;
  int         nx_dec;
  bit         e_v, e_e;
  int         e_dec;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pat_digit(input logic [6:0] p, input bit is_tens);
    for (int i = 0; i < 10; i++)
      if (pats[i] == p) return i;
`ifdef SEVSEG_BLANK_TENS_EN
    if (is_tens && p == 7'h00) return 0;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 9'd0; m_run = 0; m_have_tens = 0; m_tens = 0;
    nx_v = 0; nx_e = 0; nx_dec = 0;
    e_v = 0; e_e = 0; e_dec = 0;
  endtask

  // Called at each rising edge with the inputs present during the cycle just ended.
  task automatic model_edge(input logic [1:0] ds, input logic [6:0] sg);
    int d;
    e_v = nx_v; e_e = nx_e; e_dec = nx_dec;
    nx_v = 0; nx_e = 0;
    if ({ds, sg} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {ds, sg};
    if (m_run == S && (ds == 2'b10 || ds == 2'b01)) begin
      d = pat_digit(sg, ds == 2'b10);
      if (d < 0) begin
        nx_e = 1; m_have_tens = 0;
      end else if (ds == 2'b10) begin
        m_have_tens = 1; m_tens = d;
      end else if (m_have_tens) begin
        nx_v = 1; nx_dec = m_tens * 10 + d; m_have_tens = 0;
      end
    end
  endtask

  task automatic cyc(input logic [1:0] ds, input logic [6:0] sg);
    digit_sel = ds;
    seg       = sg;
    @(posedge clk);
    model_edge(ds, sg);
    #1;
    check("valid", int'(valid), int'(e_v));
    check("error", int'(error), int'(e_e));
    check("decimal", int'(decimal), e_dec);
  endtask

  task automatic hold(input logic [1:0] ds, input logic [6:0] sg, input int n);
    for (int i = 0; i < n; i++) cyc(ds, sg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_valid", int'(valid), 0);
    check("rst_error", int'(error), 0);
    check("rst_decimal", int'(decimal), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; seg = 7'h00; digit_sel = 2'b00;
    model_reset();
    #1;
    do_reset();

    // 24
    hold(2'b10, 7'h5B, 6);
    hold(2'b01, 7'h66, 6);
    check("dec24", int'(decimal), 24);

    // 99, 81, 72 back to back
    hold(2'b10, 7'h6F, 6); hold(2'b01, 7'h6F, 6);
    check("dec99", int'(decimal), 99);
    hold(2'b10, 7'h7F, 6); hold(2'b01, 7'h06, 6);
    check("dec81", int'(decimal), 81);
    hold(2'b10, 7'h07, 6); hold(2'b01, 7'h5B, 6);
    check("dec72", int'(decimal), 72);

    // glitch shorter than the stable window
    hold(2'b10, 7'h06, 6); hold(2'b10, 7'h7F, 2); hold(2'b10, 7'h06, 6);
    hold(2'b01, 7'h5B, 6);
    check("dec12", int'(decimal), 12);

    // blank tens
    hold(2'b10, 7'h00, 6); hold(2'b01, 7'h4F, 6);
`ifdef SEVSEG_BLANK_TENS_EN
    check("blank_tens", int'(decimal), 3);
`else
    check("blank_tens", int'(decimal), 12);
`endif

    // illegal tens, then lone ones
    hold(2'b10, 7'h49, 6); hold(2'b01, 7'h06, 6);
    hold(2'b00, 7'h00, 2);

    // reset mid-frame
    hold(2'b10, 7'h66, 6);
    do_reset();
    hold(2'b01, 7'h6D, 6);
    check("post_rst_dec", int'(decimal), 0);

    // randomised segments
    for (int k = 0; k < 250; k++) begin
      logic [1:0] ds;
      logic [6:0] sg;
      int         r;
      r  = int'($urandom_range(0, 9));
      ds = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 7) == 0) sg = 7'($urandom);
      else sg = pats[$urandom_range(0, 9)];
      hold(ds, sg, int'($urandom_range(1, 7)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    hold(2'b00, 7'h00, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
